// File: rtl/axis_wb_master_pkg.sv
// Shared encodings for the byte-stream to Wishbone master: command/status bit
// positions, FSM state codes and the address-byte-count decode.
package axis_wb_master_pkg;

  localparam int CMD_CLR   = 0;
  localparam int CMD_WE    = 1;
  localparam int CMD_INC   = 2;
  localparam int CMD_ALO   = 3;
  localparam int CMD_AHI   = 4;
  localparam int CMD_BURST = 5;

  localparam int ST_WE  = 0;
  localparam int ST_ERR = 1;
  localparam int ST_OVF = 3;
  localparam int ST_TO  = 4;

  localparam logic [1:0] ACNT_NONE = 2'd0;
  localparam logic [1:0] ACNT_ONE  = 2'd1;
  localparam logic [1:0] ACNT_TWO  = 2'd2;
  localparam logic [1:0] ACNT_FULL = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_COUNT  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_BUS    = 3'd4;
  localparam logic [2:0] S_STATUS = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  // Number of address bytes that follow a command, clamped to the bus width.
  function automatic logic [2:0] addr_count(input logic [1:0] code, input int abytes);
    int n;
    case (code)
      ACNT_NONE: n = 0;
      ACNT_ONE:  n = 1;
      ACNT_TWO:  n = 2;
      default:   n = abytes;
    endcase
    if (n > abytes) n = abytes;
    return 3'(n);
  endfunction

endpackage

// File: rtl/axis_wb_master_if.sv
// Byte-stream in/out plus Wishbone master signals of axis_wb_master.
interface axis_wb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;

  logic                  s_axis_ready;
  logic                  s_axis_valid;
  logic [7:0]            s_axis_data;
  logic                  m_axis_ready;
  logic                  m_axis_valid;
  logic [7:0]            m_axis_data;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_BYTES-1:0] wb_sel;
  logic [DATA_WIDTH-1:0] wb_data_write;
  logic [DATA_WIDTH-1:0] wb_data_read;
  logic                  wb_ack;
  logic                  wb_err;
  logic                  overflow;

  modport master (
    output s_axis_ready, input s_axis_valid, input s_axis_data,
    input m_axis_ready, output m_axis_valid, output m_axis_data,
    output wb_cyc, output wb_stb, output wb_we, output wb_addr, output wb_sel,
    output wb_data_write, input wb_data_read, input wb_ack, input wb_err,
    input overflow
  );

  modport slave (
    input s_axis_ready, output s_axis_valid, output s_axis_data,
    output m_axis_ready, input m_axis_valid, input m_axis_data,
    input wb_cyc, input wb_stb, input wb_we, input wb_addr, input wb_sel,
    input wb_data_write, output wb_data_read, output wb_ack, output wb_err,
    output overflow
  );
endinterface

// File: rtl/axis_wb_master_wb_timeout.sv
// Bus-cycle watchdog: preloaded while idle, counts down while enabled,
// flags expiry in the TIMEOUT-th enabled cycle.
module wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] INIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= INIT;
    else if (load)              cnt <= INIT;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expired = en && (cnt == '0);
endmodule

// File: rtl/axis_wb_master.sv
// Byte-stream command decoder driving single or burst Wishbone transactions,
// returning a status byte (and read data) per transaction.
module axis_wb_master import axis_wb_master_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic rst_n,
  axis_wb_master_if.master bus
);
  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] DLAST = 3'(DATA_BYTES - 1);

  logic [2:0]            state;
  logic                  we, inc, burst;
  logic [2:0]            akeep, byte_cnt, k_cmd;
  logic [7:0]            burst_cnt, m_data, status;
  logic [ADDR_WIDTH-1:0] addr, amask;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic                  ovf_lat, expired, s_fire, m_fire, term, to_hit;
  logic [2:0]            nxt_txn;
  logic [7:0]            d;

  assign d      = bus.s_axis_data;
  assign s_fire = bus.s_axis_valid && bus.s_axis_ready;
  assign m_fire = bus.m_axis_valid && bus.m_axis_ready;
  assign k_cmd  = addr_count(d[CMD_AHI:CMD_ALO], ADDR_BYTES);
  assign amask  = (ADDR_WIDTH'(1) << (8 * akeep)) - ADDR_WIDTH'(1);

  assign bus.s_axis_ready  = (state == S_IDLE) || (state == S_ADDR) ||
                             (state == S_COUNT) || (state == S_DATA);
  assign bus.m_axis_valid  = (state == S_STATUS) || (state == S_RESP);
  assign bus.m_axis_data   = m_data;
  assign bus.wb_cyc        = (state == S_BUS);
  assign bus.wb_stb        = (state == S_BUS);
  assign bus.wb_we         = we;
  assign bus.wb_addr       = addr;
  assign bus.wb_sel        = '1;
  assign bus.wb_data_write = wdata;

  // An ack/err arriving together with expiry counts as a normal termination.
  assign term    = (state == S_BUS) && (bus.wb_ack || bus.wb_err || expired);
  assign to_hit  = expired && !bus.wb_ack && !bus.wb_err;
  assign nxt_txn = (burst_cnt == 8'd0) ? S_IDLE : (we ? S_DATA : S_BUS);

  always_comb begin
    status         = '0;
    status[ST_WE]  = we;
    status[ST_ERR] = bus.wb_err || to_hit;
    status[ST_OVF] = ovf_lat || bus.overflow;
    status[ST_TO]  = to_hit;
  end

  generate
    if (TIMEOUT > 0) begin : g_to
      wb_timeout #(.TIMEOUT(TIMEOUT)) u_to (
        .clk(clk), .rst_n(rst_n), .load(state != S_BUS), .en(state == S_BUS),
        .expired(expired)
      );
    end else begin : g_no_to
      assign expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; we <= 1'b0; inc <= 1'b0; burst <= 1'b0;
      akeep <= '0; byte_cnt <= '0; burst_cnt <= '0;
      addr <= '0; wdata <= '0; rdata <= '0; m_data <= '0; ovf_lat <= 1'b0;
    end else begin
      ovf_lat <= ovf_lat || bus.overflow;
      case (state)
        S_IDLE: if (s_fire) begin
          we <= d[CMD_WE]; inc <= d[CMD_INC]; burst <= d[CMD_BURST];
          akeep <= k_cmd; burst_cnt <= '0; byte_cnt <= k_cmd - 3'd1;
          if (d[CMD_CLR]) addr <= '0;
          if (k_cmd != '0)          state <= S_ADDR;
          else if (d[CMD_BURST])    state <= S_COUNT;
          else if (d[CMD_WE])       begin state <= S_DATA; byte_cnt <= DLAST; end
          else                      state <= S_BUS;
        end
        // Each byte shifts into the low 8*k bits only; upper bits are kept.
        S_ADDR: if (s_fire) begin
          addr     <= (addr & ~amask) | (((addr << 8) | ADDR_WIDTH'(d)) & amask);
          byte_cnt <= byte_cnt - 3'd1;
          if (byte_cnt == '0) begin
            if (burst)   state <= S_COUNT;
            else if (we) begin state <= S_DATA; byte_cnt <= DLAST; end
            else         state <= S_BUS;
          end
        end
        S_COUNT: if (s_fire) begin
          burst_cnt <= d;
          byte_cnt  <= DLAST;
          state     <= we ? S_DATA : S_BUS;
        end
        S_DATA: if (s_fire) begin
          wdata    <= (wdata << 8) | DATA_WIDTH'(d);
          byte_cnt <= byte_cnt - 3'd1;
          if (byte_cnt == '0) state <= S_BUS;
        end
        S_BUS: if (term) begin
          state   <= S_STATUS;
          m_data  <= status;
          ovf_lat <= 1'b0;
          if (!we) rdata <= bus.wb_data_read;
          if (inc) addr  <= addr + ADDR_WIDTH'(1);
        end
        S_STATUS: if (m_fire) begin
          if (!we && !m_data[ST_ERR]) begin
            state    <= S_RESP;
            m_data   <= rdata[DATA_WIDTH-1 -: 8];
            rdata    <= rdata << 8;
            byte_cnt <= DLAST;
          end else begin
            state <= nxt_txn; burst_cnt <= burst_cnt - 8'd1; byte_cnt <= DLAST;
          end
        end
        S_RESP: if (m_fire) begin
          if (byte_cnt == '0) begin
            state <= nxt_txn; burst_cnt <= burst_cnt - 8'd1; byte_cnt <= DLAST;
          end else begin
            m_data   <= rdata[DATA_WIDTH-1 -: 8];
            rdata    <= rdata << 8;
            byte_cnt <= byte_cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
